// File: rtl/udc_pkg.sv
// Shared types and defaults for the parametrised up/down counter family.
package udc_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_SAT  = 1'b0,
    MODE_WRAP = 1'b1
  } mode_e;

  localparam int UDC_DEFAULT_WIDTH = 24;

endpackage

// File: rtl/udc_next_count.sv
// Combinational next-state for one counter stage: boundary detection,
// load clamping, wrap/saturate decisions and the cascade terminal count.
module udc_next_count
  import udc_pkg::*;
#(
  parameter int WIDTH = UDC_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic             saturated,
  input  logic             active,
  input  logic             up_down,
  input  logic             wrap_mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count_next,
  output logic             wrap_next,
  output logic             sat_next,
  output logic             at_top,
  output logic             at_bot,
  output logic             tc
);

  dir_e  dir;
  mode_e mode;

  assign dir  = dir_e'(up_down);
  assign mode = mode_e'(wrap_mode);

  // >= keeps the counter well-behaved when limit drops below count mid-run.
  assign at_top = (count >= limit);
  assign at_bot = (count == '0);
  assign tc     = active & ((dir == DIR_UP) ? at_top : at_bot);

  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    sat_next   = saturated & (mode == MODE_SAT);
    if (load) begin
      count_next = (load_value > limit) ? limit : load_value;
      sat_next   = 1'b0;
    end else if (active) begin
      if (dir == DIR_UP) begin
        if (!at_top) begin
          // count < limit here, so the increment cannot overflow WIDTH bits
          count_next = count + 1'b1;
          sat_next   = 1'b0;
        end else if (mode == MODE_WRAP) begin
          count_next = '0;
          wrap_next  = 1'b1;
          sat_next   = 1'b0;
        end else begin
          count_next = limit;
          sat_next   = 1'b1;
        end
      end else begin
        if (!at_bot) begin
          count_next = count - 1'b1;
          sat_next   = 1'b0;
        end else if (mode == MODE_WRAP) begin
          count_next = limit;
          wrap_next  = 1'b1;
          sat_next   = 1'b0;
        end else begin
          count_next = count;
          sat_next   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Cascadable up/down counter stage with terminal limit, wrap/saturate mode and load.
// Optional snapshot register (snap / snap_count) enabled by defining UDC_SNAPSHOT_EN.
module param_updown_counter
  import udc_pkg::*;
#(
  parameter int               WIDTH       = UDC_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_in,
  input  logic             en_local,
  input  logic             up_down,
  input  logic             wrap_mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
`ifdef UDC_SNAPSHOT_EN
  input  logic             snap,
  output logic [WIDTH-1:0] snap_count,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc_out,
  output logic             wrap_pulse,
  output logic             saturated
);

  logic             active;
  logic [WIDTH-1:0] count_next;
  logic             wrap_next;
  logic             sat_next;
  logic             at_top;
  logic             at_bot;

  assign active = en_in & en_local;

  udc_next_count #(.WIDTH(WIDTH)) u_next (
    .count      (count),
    .saturated  (saturated),
    .active     (active),
    .up_down    (up_down),
    .wrap_mode  (wrap_mode),
    .limit      (limit),
    .load       (load),
    .load_value (load_value),
    .count_next (count_next),
    .wrap_next  (wrap_next),
    .sat_next   (sat_next),
    .at_top     (at_top),
    .at_bot     (at_bot),
    .tc         (tc_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= RESET_VALUE;
      wrap_pulse <= 1'b0;
      saturated  <= 1'b0;
    end else begin
      count      <= count_next;
      wrap_pulse <= wrap_next;
      saturated  <= sat_next;
    end
  end

`ifdef UDC_SNAPSHOT_EN
  // Captures the value before this edge's update.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_count <= '0;
    end else if (snap) begin
      snap_count <= count;
    end
  end
`endif

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: single 4-bit stage, a 4-bit two-stage
// cascade and a 24-bit stage with non-zero reset value.
module tb_param_updown_counter;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  // single 4-bit stage
  logic       a_reset, a_en_in, a_en_local, a_up, a_wrap, a_load;
  logic [3:0] a_limit, a_load_value, a_count;
  logic       a_tc, a_wp, a_sat;

  param_updown_counter #(.WIDTH(4), .RESET_VALUE(4'd0)) dut4 (
    .clk(clk), .reset(a_reset), .en_in(a_en_in), .en_local(a_en_local),
    .up_down(a_up), .wrap_mode(a_wrap), .limit(a_limit), .load(a_load),
    .load_value(a_load_value), .count(a_count), .tc_out(a_tc),
    .wrap_pulse(a_wp), .saturated(a_sat)
  );

  // two-stage 4-bit cascade
  logic       c_reset, c_en_local;
  logic [3:0] c0_count, c1_count;
  logic       c0_tc, c1_tc, c0_wp, c1_wp, c0_sat, c1_sat;

  param_updown_counter #(.WIDTH(4)) casc0 (
    .clk(clk), .reset(c_reset), .en_in(1'b1), .en_local(c_en_local),
    .up_down(1'b1), .wrap_mode(1'b1), .limit(4'd9), .load(1'b0),
    .load_value(4'd0), .count(c0_count), .tc_out(c0_tc),
    .wrap_pulse(c0_wp), .saturated(c0_sat)
  );

  param_updown_counter #(.WIDTH(4)) casc1 (
    .clk(clk), .reset(c_reset), .en_in(c0_tc), .en_local(c_en_local),
    .up_down(1'b1), .wrap_mode(1'b1), .limit(4'd9), .load(1'b0),
    .load_value(4'd0), .count(c1_count), .tc_out(c1_tc),
    .wrap_pulse(c1_wp), .saturated(c1_sat)
  );

  // 24-bit stage
  logic        b_reset, b_en_in, b_en_local, b_up, b_wrap, b_load;
  logic [23:0] b_limit, b_load_value, b_count;
  logic        b_tc, b_wp, b_sat;

  param_updown_counter #(.WIDTH(24), .RESET_VALUE(24'd7)) dut24 (
    .clk(clk), .reset(b_reset), .en_in(b_en_in), .en_local(b_en_local),
    .up_down(b_up), .wrap_mode(b_wrap), .limit(b_limit), .load(b_load),
    .load_value(b_load_value), .count(b_count), .tc_out(b_tc),
    .wrap_pulse(b_wp), .saturated(b_sat)
  );

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [3:0] value, input logic [3:0] lim);
    a_limit = lim;
    a_load_value = value;
    a_load = 1'b1;
    step();
    a_load = 1'b0;
  endtask

  task automatic load_b(input logic [23:0] value, input logic [23:0] lim);
    b_limit = lim;
    b_load_value = value;
    b_load = 1'b1;
    step();
    b_load = 1'b0;
  endtask

  // scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    logic [3:0] cur;
    logic [3:0] m0, m1;
    logic [31:0] e;

    a_reset = 1'b1; a_en_in = 1'b1; a_en_local = 1'b0; a_up = 1'b1; a_wrap = 1'b1;
    a_load = 1'b0; a_limit = 4'd15; a_load_value = 4'd0;
    c_reset = 1'b1; c_en_local = 1'b0;
    b_reset = 1'b1; b_en_in = 1'b1; b_en_local = 1'b0; b_up = 1'b1; b_wrap = 1'b1;
    b_load = 1'b0; b_limit = 24'hFFFFFF; b_load_value = 24'd0;
    step();
    step();

    // reset and clamped load
    check("rst_count", a_count, 0);
    check("rst_wp", a_wp, 0);
    check("rst_sat", a_sat, 0);
    a_reset = 1'b0;
    load_a(4'd12, 4'd9);
    check("load_clamp", a_count, 9);

    // up-wrap 0..5
    load_a(4'd0, 4'd5);
    check("load_zero", a_count, 0);
    a_wrap = 1'b1; a_up = 1'b1; a_en_local = 1'b1;
    for (int i = 1; i <= 5; i++) exp_q.push_back(i);
    exp_q.push_back(0);
    cur = 4'd0;
    while (exp_q.size() > 0) begin
      #1;
      check("upwrap_tc", a_tc, (cur == 4'd5));
      step();
      e = exp_q.pop_front();
      check("upwrap_count", a_count, e);
      check("upwrap_wp", a_wp, (e == 0));
      cur = e[3:0];
    end
    step();
    check("upwrap_wp_drop", a_wp, 0);
    check("upwrap_after", a_count, 1);

    // down-saturate from 2
    a_en_local = 1'b0;
    load_a(4'd2, 4'd5);
    a_wrap = 1'b0; a_up = 1'b0; a_en_local = 1'b1;
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("downsat_count", a_count, exp_q.pop_front());
      check("downsat_sat", a_sat, (i >= 2));
    end
    #1;
    check("downsat_tc", a_tc, 1);
    a_up = 1'b1;
    step();
    check("downsat_up_count", a_count, 1);
    check("downsat_up_sat", a_sat, 0);

    // limit lowered below count, wrap then saturate
    a_en_local = 1'b0;
    load_a(4'd8, 4'd9);
    check("lower_load", a_count, 8);
    a_limit = 4'd3; a_wrap = 1'b1; a_en_local = 1'b1;
    step();
    check("lower_wrap_count", a_count, 0);
    check("lower_wrap_wp", a_wp, 1);
    a_en_local = 1'b0;
    load_a(4'd8, 4'd9);
    a_limit = 4'd3; a_wrap = 1'b0; a_en_local = 1'b1;
    step();
    check("lower_sat_count", a_count, 3);
    check("lower_sat_sat", a_sat, 1);
    check("lower_sat_wp", a_wp, 0);

    // limit = 0 with wrap
    a_en_local = 1'b0;
    load_a(4'd5, 4'd0);
    check("lim0_load", a_count, 0);
    a_wrap = 1'b1; a_en_local = 1'b1;
    #1;
    check("lim0_tc", a_tc, 1);
    step();
    check("lim0_count", a_count, 0);
    check("lim0_wp1", a_wp, 1);
    step();
    check("lim0_wp2", a_wp, 1);
    a_en_local = 1'b0;
    step();
    check("lim0_idle_wp", a_wp, 0);
    check("lim0_idle_tc", a_tc, 0);

    // cascade: 100 active cycles
    c_reset = 1'b0; c_en_local = 1'b1;
    m0 = 4'd0; m1 = 4'd0;
    for (int i = 0; i < 100; i++) begin
      if (m0 == 4'd9) begin
        m0 = 4'd0;
        m1 = (m1 == 4'd9) ? 4'd0 : m1 + 4'd1;
      end else begin
        m0 = m0 + 4'd1;
      end
      step();
      check("casc_c0", c0_count, m0);
      check("casc_c1", c1_count, m1);
    end
    check("casc_final0", c0_count, 0);
    check("casc_final1", c1_count, 0);

    // 24-bit: reset value, enable gating, priority, full range
    check("b_rst_count", b_count, 7);
    b_reset = 1'b0;
    load_b(24'd100, 24'hFFFFFF);
    check("b_load", b_count, 100);
    b_en_in = 1'b0; b_en_local = 1'b1; b_up = 1'b1; b_wrap = 1'b1;
    step(); step(); step();
    check("b_hold", b_count, 100);
    check("b_hold_tc", b_tc, 0);
    b_en_in = 1'b1;
    step();
    check("b_inc", b_count, 101);
    load_b(24'd50, 24'hFFFFFF);
    check("b_load_wins", b_count, 50);
    b_reset = 1'b1; b_load = 1'b1; b_load_value = 24'd200;
    step();
    b_reset = 1'b0; b_load = 1'b0;
    check("b_reset_wins", b_count, 7);
    load_b(24'hFFFFFF, 24'hFFFFFF);
    check("b_full_load", b_count, 24'hFFFFFF);
    #1;
    check("b_full_tc", b_tc, 1);
    step();
    check("b_full_wrap", b_count, 0);
    check("b_full_wp", b_wp, 1);
    load_b(24'hFFFFFF, 24'hFFFFFF);
    b_wrap = 1'b0;
    step();
    check("b_full_sat_count", b_count, 24'hFFFFFF);
    check("b_full_sat", b_sat, 1);
    b_up = 1'b0;
    step();
    check("b_down_count", b_count, 24'hFFFFFE);
    check("b_down_sat", b_sat, 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
